pagerank_row_mac: RTL and testbench
===================================

PAGERANK_ROW_MAC -- requirements
Module: pagerank_row_mac

Interface
REQ-001 Parameter nbits, default 32: width of every G and R data word.
REQ-002 Parameter max_nodes, default 8: largest supported graph size.
REQ-003 Parameter frac_bits, default 24: number of fraction bits in the unsigned fixed-point format (Q8.24 at the defaults).
REQ-004 Port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset, sampled on rising clk; the block is in reset when reset==0.
REQ-006 Port start, input, 1 bit: one-cycle job launch.
REQ-007 Port size, input, 32 bits: node count N, sampled when start is accepted.
REQ-008 Port busy, output, 1 bit: high while a job is active.
REQ-009 Port done, output, 1 bit: one-cycle pulse at the end of a job.
REQ-010 Port in_msg, input, 2*nbits bits: {g[63:32], r[31:0]}, one G-matrix element paired with its R element.
REQ-011 Ports in_val (input, 1 bit) and in_rdy (output, 1 bit): val/rdy handshake for in_msg.
REQ-012 Port out_msg, output, 3+nbits bits: {row[34:32], sum[31:0]}.
REQ-013 Ports out_val (output, 1 bit) and out_rdy (input, 1 bit): val/rdy handshake for out_msg.

Function
REQ-014 The state machine SHALL have three states: IDLE, ACCUM and OUTPUT.
REQ-015 IDLE: busy=0, in_rdy=0, out_val=0; start=1 with size!=0 latches N=min(size,max_nodes), clears row and col counters and the accumulator, and moves to ACCUM.
REQ-016 start with size==0 SHALL be ignored: the block stays in IDLE and raises no done pulse.
REQ-017 start asserted in ACCUM or OUTPUT SHALL be ignored.
REQ-018 ACCUM: in_rdy=1; each handshake (in_val&&in_rdy) adds (g*r)>>frac_bits to acc and increments col; the block accepts at most one pair per cycle.
REQ-019 Product arithmetic: the full 2*nbits unsigned product; bits [frac_bits+nbits-1:frac_bits] are kept; any nonzero bit above that field saturates the term to 0xFFFFFFFF.
REQ-020 Accumulation SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-021 When the handshake with col==N-1 occurs, the block moves to OUTPUT on the next edge; in_rdy=0 from that cycle on, so the row result is presented 1 cycle after its last pair is accepted.
REQ-022 OUTPUT: out_val=1, out_msg={row,acc}; out_msg stays stable until out_val&&out_rdy.
REQ-023 On the output handshake when row<N-1: row increments, col and acc clear, and the block returns to ACCUM.
REQ-024 On the output handshake when row==N-1: the block returns to IDLE and done=1 for exactly the following cycle; busy falls in the same cycle.
REQ-025 busy=1 in ACCUM and OUTPUT.
REQ-026 out_rdy low SHALL stall the block indefinitely with no loss or duplication of data.
REQ-027 in_val is ignored outside ACCUM.

Reset
REQ-028 While reset==0 the block SHALL be in IDLE with busy=0, done=0, in_rdy=0, out_val=0, out_msg=0, all counters=0 and acc=0.
REQ-029 Reset asserted mid-job SHALL abort the job with no done pulse; the next job starts clean.

Structure
REQ-030 The in/out message field widths and slice macros SHALL live in the shared pageRank-msgs.v package, next to the existing PageRank request/response message definitions.
REQ-031 The saturating fixed-point multiply SHALL be one sub-module, pagerank_fxmul, which is combinational and parameterised by nbits and frac_bits.
REQ-032 Packing and unpacking of in_msg and out_msg SHALL use pack/unpack helpers in that package.

Verification
REQ-033 Basic two-row job: size=2, pairs (0x01000000,0x00800000),(0x00800000,0x00800000),(0x01000000,0x01000000),(0,0x01000000), out_rdy=1 -> out {0,0x00C00000} then {1,0x01000000}; done pulses once.
REQ-034 Zero size: size=0 start -> busy stays 0, no done pulse; a following start with size=1 and pair (0x02000000,0x01800000) -> {0,0x03000000}.
REQ-035 Saturation: size=2, pairs (0xFF000000,0xFF000000) twice -> row0 sum=0xFFFFFFFF.
REQ-036 Backpressure: out_rdy=0 for 5 cycles in OUTPUT -> out_msg stable, in_rdy=0, no done pulse until the final handshake.
REQ-037 Clamp and random valid: size=20 -> exactly 8 rows of 8 pairs each, with random in_val gaps; sums match the reference model.
REQ-038 Mid-job reset: reset=0 during row 1 -> outputs return to their reset values; a fresh size=1 job completes correctly.

Source files
------------

// File: rtl/pagerank_row_mac_pkg.sv
// pagerank_row_mac_pkg
//   Shared message definitions for the PageRank row multiply-accumulate block.
//   Holds the field widths and bit positions of the in/out messages, the
//   state encoding of the row MAC controller, and the pack/unpack helpers
//   used by the RTL and by anything that builds or decodes these messages.
//   in_msg  = {g[63:32], r[31:0]}
//   out_msg = {row[34:32], sum[31:0]}
package pagerank_row_mac_pkg;

  // Message geometry.
  localparam int unsigned msg_data_w  = 32;
  localparam int unsigned msg_row_w   = 3;
  localparam int unsigned in_msg_w    = 2 * msg_data_w;
  localparam int unsigned out_msg_w   = msg_row_w + msg_data_w;

  // Field positions (msb/lsb) inside the messages.
  localparam int unsigned in_g_msb    = in_msg_w - 1;
  localparam int unsigned in_g_lsb    = msg_data_w;
  localparam int unsigned in_r_msb    = msg_data_w - 1;
  localparam int unsigned in_r_lsb    = 0;
  localparam int unsigned out_row_msb = out_msg_w - 1;
  localparam int unsigned out_row_lsb = msg_data_w;
  localparam int unsigned out_sum_msb = msg_data_w - 1;
  localparam int unsigned out_sum_lsb = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  typedef struct packed {
    logic [msg_data_w-1:0] g;
    logic [msg_data_w-1:0] r;
  } in_msg_t;

  typedef struct packed {
    logic [msg_row_w-1:0]  row;
    logic [msg_data_w-1:0] sum;
  } out_msg_t;

  function automatic logic [in_msg_w-1:0] pack_in(
    input logic [msg_data_w-1:0] g,
    input logic [msg_data_w-1:0] r
  );
    in_msg_t m;
    m.g = g;
    m.r = r;
    return m;
  endfunction

  function automatic in_msg_t unpack_in(input logic [in_msg_w-1:0] raw);
    return in_msg_t'(raw);
  endfunction

  function automatic logic [out_msg_w-1:0] pack_out(
    input logic [msg_row_w-1:0]  row,
    input logic [msg_data_w-1:0] sum
  );
    out_msg_t m;
    m.row = row;
    m.sum = sum;
    return m;
  endfunction

  function automatic out_msg_t unpack_out(input logic [out_msg_w-1:0] raw);
    return out_msg_t'(raw);
  endfunction

endpackage

// File: rtl/pagerank_fxmul.sv
// pagerank_fxmul
//   Combinational saturating unsigned fixed-point multiply.
//   y = (a*b) >> frac_bits, clamped to all ones when the shifted product
//   does not fit in nbits.
//   Ports:
//     a, b : nbits-wide unsigned fixed-point operands
//     y    : nbits-wide saturated product
module pagerank_fxmul #(
  parameter int nbits     = 32,
  parameter int frac_bits = 24
) (
  input  logic [nbits-1:0] a,
  input  logic [nbits-1:0] b,
  output logic [nbits-1:0] y
);

  logic [2*nbits-1:0] prod_s;
  logic [2*nbits-1:0] shifted_s;

  assign prod_s    = {{nbits{1'b0}}, a} * {{nbits{1'b0}}, b};
  // After the shift the upper nbits hold everything above the kept field;
  // testing all of them covers the overflow case in one reduction.
  assign shifted_s = prod_s >> frac_bits;

  // Saturate the term when any bit above the kept field is set.
  always_comb begin
    y = {nbits{1'b0}};
    if (|shifted_s[2*nbits-1:nbits]) begin
      y = {nbits{1'b1}};
    end else begin
      y = shifted_s[nbits-1:0];
    end
  end

endmodule

// File: rtl/pagerank_row_mac.sv
// pagerank_row_mac
//   Computes one PageRank matrix-vector pass row by row: for each of N rows
//   it accepts N (g, r) pairs, accumulates the saturating fixed-point
//   products, and emits {row, sum}.
//   Ports:
//     clk, reset     : clock and synchronous active-low reset
//     start, size    : job launch and node count (clamped to max_nodes)
//     busy, done     : job active flag and one-cycle completion pulse
//     in_msg/val/rdy : {g, r} pair stream
//     out_msg/val/rdy: {row, sum} result stream
module pagerank_row_mac
  import pagerank_row_mac_pkg::*;
#(
  parameter int nbits     = 32,
  parameter int max_nodes = 8,
  parameter int frac_bits = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          size,
  output logic                 busy,
  output logic                 done,
  input  logic [2*nbits-1:0]   in_msg,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [3+nbits-1:0]   out_msg,
  output logic                 out_val,
  input  logic                 out_rdy
);

  // Counters carry one extra bit so N itself (up to max_nodes) fits.
  localparam int cnt_w = msg_row_w + 1;
  localparam logic [cnt_w-1:0] max_n = cnt_w'(max_nodes);

  state_e              state_r;
  logic [cnt_w-1:0]    n_r;
  logic [cnt_w-1:0]    row_r;
  logic [cnt_w-1:0]    col_r;
  logic [nbits-1:0]    acc_r;
  logic                busy_r;
  logic                done_r;
  logic                in_rdy_r;
  logic                out_val_r;
  logic [3+nbits-1:0]  out_msg_r;

  in_msg_t             in_fields_s;
  logic [nbits-1:0]    term_s;
  logic [nbits:0]      sum_ext_s;
  logic [nbits-1:0]    acc_next_s;
  logic [cnt_w-1:0]    n_clamp_s;
  logic [cnt_w-1:0]    n_minus1_s;

  assign in_fields_s = unpack_in(in_msg);

  pagerank_fxmul #(
    .nbits     (nbits),
    .frac_bits (frac_bits)
  ) u_fxmul (
    .a (in_fields_s.g),
    .b (in_fields_s.r),
    .y (term_s)
  );

  assign sum_ext_s  = {1'b0, acc_r} + {1'b0, term_s};
  assign n_minus1_s = n_r - {{(cnt_w-1){1'b0}}, 1'b1};

  // Saturating accumulate: a carry out clamps the running sum to all ones.
  always_comb begin
    acc_next_s = {nbits{1'b0}};
    if (sum_ext_s[nbits]) begin
      acc_next_s = {nbits{1'b1}};
    end else begin
      acc_next_s = sum_ext_s[nbits-1:0];
    end
  end

  // Clamp the requested node count to the supported graph size.
  always_comb begin
    n_clamp_s = {cnt_w{1'b0}};
    if (size > 32'(max_nodes)) begin
      n_clamp_s = max_n;
    end else begin
      n_clamp_s = size[cnt_w-1:0];
    end
  end

  // Controller: state, counters, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      n_r       <= {cnt_w{1'b0}};
      row_r     <= {cnt_w{1'b0}};
      col_r     <= {cnt_w{1'b0}};
      acc_r     <= {nbits{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      in_rdy_r  <= 1'b0;
      out_val_r <= 1'b0;
      out_msg_r <= {(3+nbits){1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (size != 32'd0)) begin
            n_r      <= n_clamp_s;
            row_r    <= {cnt_w{1'b0}};
            col_r    <= {cnt_w{1'b0}};
            acc_r    <= {nbits{1'b0}};
            busy_r   <= 1'b1;
            in_rdy_r <= 1'b1;
            state_r  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (in_val && in_rdy_r) begin
            acc_r <= acc_next_s;
            col_r <= col_r + {{(cnt_w-1){1'b0}}, 1'b1};
            // Last pair of the row: present the result on the next cycle,
            // built from the sum that includes this final term.
            if (col_r == n_minus1_s) begin
              in_rdy_r  <= 1'b0;
              out_val_r <= 1'b1;
              out_msg_r <= pack_out(row_r[msg_row_w-1:0], acc_next_s);
              state_r   <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          if (out_rdy) begin
            out_val_r <= 1'b0;
            if (row_r == n_minus1_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              row_r    <= row_r + {{(cnt_w-1){1'b0}}, 1'b1};
              col_r    <= {cnt_w{1'b0}};
              acc_r    <= {nbits{1'b0}};
              in_rdy_r <= 1'b1;
              state_r  <= ST_ACCUM;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          in_rdy_r  <= 1'b0;
          out_val_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign in_rdy  = in_rdy_r;
  assign out_val = out_val_r;
  assign out_msg = out_msg_r;

endmodule

// File: tb/tb_pagerank_row_mac.sv
module tb_pagerank_row_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] size = 32'd0;
  logic        busy;
  logic        done;
  logic [63:0] in_msg = 64'd0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [34:0] out_msg;
  logic        out_val;
  logic        out_rdy = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  pagerank_row_mac dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .size    (size),
    .busy    (busy),
    .done    (done),
    .in_msg  (in_msg),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out_msg (out_msg),
    .out_val (out_val),
    .out_rdy (out_rdy)
  );

  always #5 clk = ~clk;

  // Count done pulses shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference term: (g*r)>>24 with saturation on overflow above the field.
  function automatic logic [31:0] ref_term(input logic [31:0] g, input logic [31:0] r);
    logic [63:0] p;
    p = {32'd0, g} * {32'd0, r};
    if (p[63:56] != 8'd0) return 32'hFFFF_FFFF;
    return p[55:24];
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[32]) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic start_job(input logic [31:0] n);
    start = 1'b1;
    size  = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] g, input logic [31:0] r, output bit ok);
    in_msg = {g, r};
    in_val = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (in_rdy === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_val = 1'b0;
  endtask

  task automatic recv(output logic [34:0] m, output bit ok);
    ok = 1'b0;
    m = 35'd0;
    for (int k = 0; k < 100; k++) begin
      if (out_val === 1'b1 && out_rdy === 1'b1) begin
        m = out_msg;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, in_rdy, out_val, out_msg} !== 39'd0)
      $display("FAIL reset_state: busy=%0b done=%0b in_rdy=%0b out_val=%0b out_msg=%h required all zero", busy, done, in_rdy, out_val, out_msg);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [34:0] m;
    bit ok, all_ok;
    done_cnt = 0;
    start_job(32'd2);
    total_cnt++;
    if (busy !== 1'b1 || in_rdy !== 1'b1)
      $display("FAIL basic_launch: busy=%0b in_rdy=%0b required 1 1", busy, in_rdy);
    else pass_cnt++;
    all_ok = 1'b1;
    send_pair(32'h0100_0000, 32'h0080_0000, ok); all_ok &= ok;
    send_pair(32'h0080_0000, 32'h0080_0000, ok); all_ok &= ok;
    total_cnt++;
    if (!all_ok || in_rdy !== 1'b0 || out_val !== 1'b1)
      $display("FAIL basic_row0_turn: accepted=%0b in_rdy=%0b out_val=%0b required 1 0 1", all_ok, in_rdy, out_val);
    else pass_cnt++;
    recv(m, ok);
    total_cnt++;
    if (!ok || m !== {3'd0, 32'h00C0_0000})
      $display("FAIL basic_row0: got %h (ok=%0b) required %h", m, ok, {3'd0, 32'h00C0_0000});
    else pass_cnt++;
    all_ok = 1'b1;
    send_pair(32'h0100_0000, 32'h0100_0000, ok); all_ok &= ok;
    send_pair(32'h0000_0000, 32'h0100_0000, ok); all_ok &= ok;
    recv(m, ok);
    total_cnt++;
    if (!all_ok || !ok || m !== {3'd1, 32'h0100_0000})
      $display("FAIL basic_row1: got %h (ok=%0b acc=%0b) required %h", m, ok, all_ok, {3'd1, 32'h0100_0000});
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done_edge: done=%0b busy=%0b required 1 0", done, busy);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (done_cnt !== 1 || done !== 1'b0)
      $display("FAIL basic_done_once: pulses=%0d done=%0b required 1 0", done_cnt, done);
    else pass_cnt++;
  endtask

  task automatic test_zero_size();
    logic [34:0] m;
    bit ok, ok2;
    done_cnt = 0;
    in_msg = {32'h1234_5678, 32'h9ABC_DEF0};
    in_val = 1'b1;
    start_job(32'd0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || in_rdy !== 1'b0 || done_cnt !== 0)
      $display("FAIL zero_size_ignored: busy=%0b in_rdy=%0b pulses=%0d required 0 0 0", busy, in_rdy, done_cnt);
    else pass_cnt++;
    in_val = 1'b0;
    start_job(32'd1);
    send_pair(32'h0200_0000, 32'h0180_0000, ok);
    recv(m, ok2);
    total_cnt++;
    if (!ok || !ok2 || m !== {3'd0, 32'h0300_0000})
      $display("FAIL size1_job: got %h (ok=%0b/%0b) required %h", m, ok, ok2, {3'd0, 32'h0300_0000});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [34:0] m;
    bit ok, all_ok;
    start_job(32'd2);
    all_ok = 1'b1;
    send_pair(32'hFF00_0000, 32'hFF00_0000, ok); all_ok &= ok;
    send_pair(32'hFF00_0000, 32'hFF00_0000, ok); all_ok &= ok;
    recv(m, ok);
    total_cnt++;
    if (!all_ok || !ok || m !== {3'd0, 32'hFFFF_FFFF})
      $display("FAIL sat_product: got %h (ok=%0b) required %h", m, ok, {3'd0, 32'hFFFF_FFFF});
    else pass_cnt++;
    // Each term is exactly 0x80000000 (no product overflow); the sum carries.
    all_ok = 1'b1;
    send_pair(32'h8000_0000, 32'h0100_0000, ok); all_ok &= ok;
    send_pair(32'h8000_0000, 32'h0100_0000, ok); all_ok &= ok;
    recv(m, ok);
    total_cnt++;
    if (!all_ok || !ok || m !== {3'd1, 32'hFFFF_FFFF})
      $display("FAIL sat_accum: got %h (ok=%0b) required %h", m, ok, {3'd1, 32'hFFFF_FFFF});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [34:0] m;
    bit ok;
    done_cnt = 0;
    out_rdy = 1'b0;
    start_job(32'd1);
    send_pair(32'h0100_0000, 32'h0040_0000, ok);
    start = 1'b1;
    size = 32'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      total_cnt++;
      if (out_val !== 1'b1 || out_msg !== {3'd0, 32'h0040_0000} || in_rdy !== 1'b0 || done_cnt !== 0)
        $display("FAIL stall_cycle%0d: out_val=%0b out_msg=%h in_rdy=%0b pulses=%0d required 1 %h 0 0", c, out_val, out_msg, in_rdy, done_cnt, {3'd0, 32'h0040_0000});
      else pass_cnt++;
    end
    out_rdy = 1'b1;
    recv(m, ok);
    total_cnt++;
    if (!ok || m !== {3'd0, 32'h0040_0000} || done !== 1'b1)
      $display("FAIL stall_release: got %h ok=%0b done=%0b required %h 1 1", m, ok, done, {3'd0, 32'h0040_0000});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done_cnt !== 1)
      $display("FAIL stall_start_ignored: busy=%0b pulses=%0d required 0 1", busy, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_clamp_random();
    logic [34:0] m;
    logic [31:0] g, r, exp_sum;
    bit ok, all_ok;
    done_cnt = 0;
    start_job(32'd20);
    for (int i = 0; i < 8; i++) begin
      exp_sum = 32'd0;
      all_ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        g = 32'h0010_0000 * (i + 1) + 32'h0001_0000 * j;
        r = 32'h0020_0000 * (j + 1) + 32'h0000_0100 * i;
        exp_sum = ref_add(exp_sum, ref_term(g, r));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_pair(g, r, ok);
        all_ok &= ok;
      end
      recv(m, ok);
      total_cnt++;
      if (!all_ok || !ok || m !== {i[2:0], exp_sum})
        $display("FAIL clamp_row%0d: got %h (ok=%0b) required %h", i, m, ok, {i[2:0], exp_sum});
      else pass_cnt++;
    end
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL clamp_end: done=%0b busy=%0b required 1 0", done, busy);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (out_val !== 1'b0 || in_rdy !== 1'b0 || done_cnt !== 1)
      $display("FAIL clamp_no_extra: out_val=%0b in_rdy=%0b pulses=%0d required 0 0 1", out_val, in_rdy, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [34:0] m;
    bit ok, ok2;
    done_cnt = 0;
    start_job(32'd2);
    send_pair(32'h0100_0000, 32'h0100_0000, ok);
    send_pair(32'h0100_0000, 32'h0100_0000, ok);
    recv(m, ok);
    send_pair(32'h0300_0000, 32'h0100_0000, ok);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, in_rdy, out_val, out_msg} !== 39'd0)
      $display("FAIL mid_reset_state: busy=%0b done=%0b in_rdy=%0b out_val=%0b out_msg=%h required all zero", busy, done, in_rdy, out_val, out_msg);
    else pass_cnt++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    start_job(32'd1);
    send_pair(32'h0080_0000, 32'h0200_0000, ok);
    recv(m, ok2);
    total_cnt++;
    if (!ok || !ok2 || m !== {3'd0, 32'h0100_0000})
      $display("FAIL after_reset_job: got %h (ok=%0b/%0b) required %h", m, ok, ok2, {3'd0, 32'h0100_0000});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (done_cnt !== 1)
      $display("FAIL mid_reset_pulses: pulses=%0d required 1", done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_size();
    test_saturation();
    test_backpressure();
    test_clamp_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
